// File: rtl/ddr_wb_pkg.sv
// Shared types and constants for the Wishbone-to-MIG line bridge.
// Holds the FSM state encodings, the MIG command codes and an elaboration-time log2 helper.
package ddr_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ACK  = 3'd3
  } state_e;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // Ceiling log2 for elaboration-time width calculations; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ddr_wb_line_bridge_beat_counter.sv
// Saturating beat counter: counts from 0 up to BEATS, then holds.
// A clear takes priority over an increment.
module beat_counter
  import ddr_wb_pkg::*;
#(
  parameter int unsigned BEATS = 2,
  parameter int unsigned CNT_W = clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(BEATS))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CNT_W'(BEATS));

endmodule

// File: rtl/ddr_wb_line_bridge.sv
// Wishbone line slave to MIG user interface: one cache line per transaction, split into
// BEATS application beats, with command and write-data issue running independently.
module ddr_wb_line_bridge
  import ddr_wb_pkg::*;
#(
  parameter int unsigned LINE_BITS      = 512,
  parameter int unsigned APP_DATA_BITS  = 256,
  parameter int unsigned APP_ADDR_BITS  = 28,
  parameter int unsigned BEAT_ADDR_STEP = 8,
  parameter int unsigned MEM_BYTES_LOG2 = 29
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                ws_addr,
  input  logic [LINE_BITS-1:0]       ws_din,
  input  logic [LINE_BITS/8-1:0]     ws_dm,
  input  logic                       ws_cyc,
  input  logic                       ws_stb,
  input  logic                       ws_we,
  output logic                       ws_ack,
  output logic                       ws_err,
  output logic [LINE_BITS-1:0]       ws_dout,
  input  logic                       calib_done,
  output logic [APP_ADDR_BITS-1:0]   app_addr,
  output logic [2:0]                 app_cmd,
  output logic                       app_en,
  input  logic                       app_rdy,
  output logic [APP_DATA_BITS-1:0]   app_wdf_data,
  output logic [APP_DATA_BITS/8-1:0] app_wdf_mask,
  output logic                       app_wdf_wren,
  output logic                       app_wdf_end,
  input  logic                       app_wdf_rdy,
  input  logic [APP_DATA_BITS-1:0]   app_rd_data,
  input  logic                       app_rd_data_valid,
  output logic [2:0]                 dbg_state
);

  localparam int unsigned BEATS           = LINE_BITS / APP_DATA_BITS;
  localparam int unsigned BEATS_LOG2      = clog2(BEATS);
  localparam int unsigned CNT_W           = clog2(BEATS + 1);
  localparam int unsigned LINE_BYTES_LOG2 = clog2(LINE_BITS / 8);
  localparam int unsigned LINE_W          = MEM_BYTES_LOG2 - LINE_BYTES_LOG2;
  localparam int unsigned STEP_LOG2       = clog2(BEAT_ADDR_STEP);
  localparam int unsigned CALC_W          = LINE_W + BEATS_LOG2 + STEP_LOG2 + 1;
  localparam int unsigned DM_W            = LINE_BITS / 8;
  localparam int unsigned MASK_W          = APP_DATA_BITS / 8;

  if (((LINE_BITS % APP_DATA_BITS) != 0) || (BEATS == 0) || ((BEATS & (BEATS - 1)) != 0) ||
      (MEM_BYTES_LOG2 > 32) || (MEM_BYTES_LOG2 <= LINE_BYTES_LOG2)) begin : g_param_check
    $error("ddr_wb_line_bridge: illegal LINE_BITS/APP_DATA_BITS/MEM_BYTES_LOG2 combination");
  end

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [LINE_BITS-1:0] wr_line_q, wr_line_d;
  logic [DM_W-1:0]      wr_dm_q, wr_dm_d;
  logic [LINE_BITS-1:0] rd_buf_q, rd_buf_d;
  logic [LINE_BITS-1:0] dout_q, dout_d;

  logic             cnt_clr;
  logic             cmd_inc, dat_inc, rd_inc;
  logic [CNT_W-1:0] cmd_cnt, dat_cnt, rd_cnt;
  logic             cmd_done, dat_done;
  logic             rd_done_unused;
  logic             cmd_last, dat_last;
  logic             addr_err;
  logic [CALC_W-1:0] beat_idx;
  logic             unused_addr_lo;

  assign unused_addr_lo = ^ws_addr[LINE_BYTES_LOG2-1:0];
  assign addr_err       = ((ws_addr >> MEM_BYTES_LOG2) != 32'd0);

  beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_cmd_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cmd_inc), .cnt(cmd_cnt), .done(cmd_done)
  );
  beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_dat_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(dat_inc), .cnt(dat_cnt), .done(dat_done)
  );
  beat_counter #(.BEATS(BEATS), .CNT_W(CNT_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(rd_inc), .cnt(rd_cnt), .done(rd_done_unused)
  );

  // MIG-facing strobes, address and write slices decoded from state and beat counters.
  always_comb begin
    app_en       = 1'b0;
    app_cmd      = MIG_CMD_WRITE;
    app_wdf_wren = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '1;
    unique case (state_q)
      ST_WR: begin
        app_en       = !cmd_done;
        app_wdf_wren = !dat_done;
      end
      ST_RD: begin
        app_en  = !cmd_done;
        app_cmd = MIG_CMD_READ;
      end
      default: ;
    endcase
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (dat_cnt == CNT_W'(b)) begin
        app_wdf_data = wr_line_q[b*APP_DATA_BITS +: APP_DATA_BITS];
        app_wdf_mask = ~wr_dm_q[b*MASK_W +: MASK_W];
      end
    end
    beat_idx = (CALC_W'(line_q) << BEATS_LOG2) + CALC_W'(cmd_cnt);
    app_addr = APP_ADDR_BITS'(beat_idx << STEP_LOG2);
  end

  assign app_wdf_end = app_wdf_wren;
  assign cmd_inc     = app_en & app_rdy;
  assign dat_inc     = app_wdf_wren & app_wdf_rdy;
  assign rd_inc      = (state_q == ST_RD) & app_rd_data_valid;

  // A counter is finished if it already sits at BEATS or reaches it this cycle.
  assign cmd_last = cmd_done | (cmd_inc & (cmd_cnt == CNT_W'(BEATS - 1)));
  assign dat_last = dat_done | (dat_inc & (dat_cnt == CNT_W'(BEATS - 1)));

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    line_d    = line_q;
    wr_line_d = wr_line_q;
    wr_dm_d   = wr_dm_q;
    rd_buf_d  = rd_buf_q;
    dout_d    = dout_q;
    cnt_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ws_cyc && ws_stb && calib_done) begin
          cnt_clr = 1'b1;
          line_d  = ws_addr[MEM_BYTES_LOG2-1:LINE_BYTES_LOG2];
          if (addr_err) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else if (ws_we) begin
            wr_line_d = ws_din;
            wr_dm_d   = ws_dm;
            ack_d     = 1'b1;
            state_d   = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (cmd_last && dat_last) state_d = ST_IDLE;
      end
      ST_RD: begin
        if (app_rd_data_valid) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (rd_cnt == CNT_W'(b)) rd_buf_d[b*APP_DATA_BITS +: APP_DATA_BITS] = app_rd_data;
          end
          if (rd_cnt == CNT_W'(BEATS - 1)) begin
            dout_d  = rd_buf_d;
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      line_q    <= '0;
      wr_line_q <= '0;
      wr_dm_q   <= '0;
      rd_buf_q  <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      line_q    <= line_d;
      wr_line_q <= wr_line_d;
      wr_dm_q   <= wr_dm_d;
      rd_buf_q  <= rd_buf_d;
      dout_q    <= dout_d;
    end
  end

  assign ws_ack    = ack_q;
  assign ws_err    = err_q;
  assign ws_dout   = dout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr_wb_line_bridge.sv
// Directed bench for ddr_wb_line_bridge: a default 512/256 instance and a 1024/128 instance
// share one clock and reset; each step drives inputs and samples 1 time unit after posedge.
module tb_ddr_wb_line_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance (BEATS = 2).
  logic [31:0]  ws_addr;
  logic [511:0] ws_din;
  logic [63:0]  ws_dm;
  logic         ws_cyc, ws_stb, ws_we, ws_ack, ws_err;
  logic [511:0] ws_dout;
  logic         calib_done;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic [2:0]   dbg_state;

  // Wide-line instance (BEATS = 8).
  logic [31:0]   ws_addr8;
  logic [1023:0] ws_din8;
  logic [127:0]  ws_dm8;
  logic          ws_cyc8, ws_stb8, ws_we8, ws_ack8, ws_err8;
  logic [1023:0] ws_dout8;
  logic [27:0]   app_addr8;
  logic [2:0]    app_cmd8;
  logic          app_en8, app_rdy8;
  logic [127:0]  app_wdf_data8;
  logic [15:0]   app_wdf_mask8;
  logic          app_wdf_wren8, app_wdf_end8, app_wdf_rdy8;
  logic [127:0]  app_rd_data8;
  logic          app_rd_data_valid8;
  logic [2:0]    dbg_state8;

  ddr_wb_line_bridge u_dut (
    .clk(clk), .rst(rst), .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
    .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack), .ws_err(ws_err),
    .ws_dout(ws_dout), .calib_done(calib_done), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .dbg_state(dbg_state)
  );

  ddr_wb_line_bridge #(.LINE_BITS(1024), .APP_DATA_BITS(128)) u_dut8 (
    .clk(clk), .rst(rst), .ws_addr(ws_addr8), .ws_din(ws_din8), .ws_dm(ws_dm8),
    .ws_cyc(ws_cyc8), .ws_stb(ws_stb8), .ws_we(ws_we8), .ws_ack(ws_ack8), .ws_err(ws_err8),
    .ws_dout(ws_dout8), .calib_done(calib_done), .app_addr(app_addr8), .app_cmd(app_cmd8),
    .app_en(app_en8), .app_rdy(app_rdy8), .app_wdf_data(app_wdf_data8),
    .app_wdf_mask(app_wdf_mask8), .app_wdf_wren(app_wdf_wren8), .app_wdf_end(app_wdf_end8),
    .app_wdf_rdy(app_wdf_rdy8), .app_rd_data(app_rd_data8),
    .app_rd_data_valid(app_rd_data_valid8), .dbg_state(dbg_state8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat8(input int k);
    return {4{32'hC000_0000 | 32'(k)}};
  endfunction

  localparam logic [255:0] RB0 = {8{32'hA000_0001}};
  localparam logic [255:0] RB1 = {8{32'hA111_0002}};
  localparam logic [255:0] WB0 = {8{32'hB000_0003}};
  localparam logic [255:0] WB1 = {8{32'hB111_0004}};
  localparam logic [255:0] DB0 = {8{32'hD000_0005}};
  localparam logic [255:0] DB1 = {8{32'hD111_0006}};

  logic saw_ack;
  logic saw_en;

  initial begin
    rst = 1'b1;
    ws_addr = '0; ws_din = '0; ws_dm = '0; ws_cyc = 0; ws_stb = 0; ws_we = 0;
    calib_done = 0; app_rdy = 0; app_wdf_rdy = 0; app_rd_data = '0; app_rd_data_valid = 0;
    ws_addr8 = '0; ws_din8 = '0; ws_dm8 = '0; ws_cyc8 = 0; ws_stb8 = 0; ws_we8 = 0;
    app_rdy8 = 0; app_wdf_rdy8 = 0; app_rd_data8 = '0; app_rd_data_valid8 = 0;
    repeat (3) step();

    // Reset values.
    check("rst_ack", ws_ack, 1'b0);
    check("rst_err", ws_err, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_dout", ws_dout, 512'd0);
    rst = 1'b0;

    // Read @0x40 held off until calibration completes.
    ws_addr = 32'h40; ws_cyc = 1; ws_stb = 1; ws_we = 0; app_rdy = 1;
    saw_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ws_ack) saw_ack = 1;
    end
    check("nocal_ack", saw_ack, 1'b0);
    check("nocal_state", dbg_state, 3'd0);
    calib_done = 1;
    step();
    ws_cyc = 0; ws_stb = 0;
    check("rd_state", dbg_state, 3'd2);
    check("rd_addr0", app_addr, 28'h10);
    check("rd_cmd", app_cmd, 3'b001);
    check("rd_en0", app_en, 1'b1);
    step();
    check("rd_addr1", app_addr, 28'h18);
    step();
    check("rd_en_off", app_en, 1'b0);
    app_rd_data_valid = 1; app_rd_data = RB0;
    step();
    check("rd_noack_b0", ws_ack, 1'b0);
    app_rd_data = RB1;
    step();
    app_rd_data_valid = 0;
    check("rd_ack", ws_ack, 1'b1);
    check("rd_err", ws_err, 1'b0);
    check("rd_dout", ws_dout, {RB1, RB0});
    check("rd_ack_state", dbg_state, 3'd3);
    step();
    check("rd_ack_clr", ws_ack, 1'b0);
    check("rd_idle", dbg_state, 3'd0);

    // Write @0x1000: data accepted first, command stalled for 5 cycles.
    app_rdy = 0; app_wdf_rdy = 1;
    ws_addr = 32'h1000; ws_din = {WB1, WB0}; ws_dm = 64'h00000000_FFFFFFFF;
    ws_we = 1; ws_cyc = 1; ws_stb = 1;
    step();
    ws_cyc = 0; ws_stb = 0; ws_we = 0;
    check("wr_ack", ws_ack, 1'b1);
    check("wr_state", dbg_state, 3'd1);
    check("wr_addr0", app_addr, 28'h400);
    check("wr_cmd", app_cmd, 3'b000);
    check("wr_mask0", app_wdf_mask, 32'h0);
    check("wr_data0", app_wdf_data, WB0);
    check("wr_end0", app_wdf_end, 1'b1);
    step();
    check("wr_ack_1cyc", ws_ack, 1'b0);
    check("wr_mask1", app_wdf_mask, 32'hFFFF_FFFF);
    check("wr_data1", app_wdf_data, WB1);
    step();
    check("wr_wren_off", app_wdf_wren, 1'b0);
    repeat (3) step();
    check("wr_stall_state", dbg_state, 3'd1);
    check("wr_stall_addr", app_addr, 28'h400);
    app_rdy = 1;
    step();
    check("wr_mid_state", dbg_state, 3'd1);
    check("wr_addr1", app_addr, 28'h408);
    step();
    app_rdy = 0;
    check("wr_done_state", dbg_state, 3'd0);
    check("wr_dout_hold", ws_dout, {RB1, RB0});

    // Write @0x1040: commands first, data afterwards.
    app_rdy = 1; app_wdf_rdy = 0;
    ws_addr = 32'h1040; ws_din = {DB1, DB0}; ws_dm = '1; ws_we = 1; ws_cyc = 1; ws_stb = 1;
    step();
    ws_cyc = 0; ws_stb = 0; ws_we = 0;
    check("wr2_addr0", app_addr, 28'h410);
    step();
    step();
    check("wr2_en_off", app_en, 1'b0);
    check("wr2_wait_state", dbg_state, 3'd1);
    app_wdf_rdy = 1;
    step();
    check("wr2_data1", app_wdf_data, DB1);
    check("wr2_en_still_off", app_en, 1'b0);
    step();
    check("wr2_done_state", dbg_state, 3'd0);
    check("wr2_wren_off", app_wdf_wren, 1'b0);

    // Write with both ready: last increments coincide, WR lasts exactly BEATS cycles.
    ws_addr = 32'h0; ws_we = 1; ws_cyc = 1; ws_stb = 1;
    step();
    ws_cyc = 0; ws_stb = 0; ws_we = 0;
    step();
    check("wr3_mid_state", dbg_state, 3'd1);
    step();
    check("wr3_done_state", dbg_state, 3'd0);
    app_rdy = 0; app_wdf_rdy = 0;

    // Out-of-range read @0x2000_0000.
    ws_addr = 32'h2000_0000; ws_we = 0; ws_cyc = 1; ws_stb = 1;
    saw_en = app_en;
    step();
    ws_cyc = 0; ws_stb = 0;
    if (app_en) saw_en = 1;
    check("err_ack", ws_ack, 1'b1);
    check("err_err", ws_err, 1'b1);
    check("err_state", dbg_state, 3'd3);
    step();
    if (app_en) saw_en = 1;
    check("err_no_app_en", saw_en, 1'b0);
    check("err_ack_clr", {ws_ack, ws_err}, 2'b00);
    check("err_idle", dbg_state, 3'd0);

    // Wide-line read @0x80, valids interleaved with commands.
    app_rdy8 = 1; ws_addr8 = 32'h80; ws_we8 = 0; ws_cyc8 = 1; ws_stb8 = 1;
    step();
    ws_cyc8 = 0; ws_stb8 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        check($sformatf("w8_addr%0d", i), app_addr8, 28'(32'h40 + 32'(8 * i)));
        check($sformatf("w8_en%0d", i), app_en8, 1'b1);
      end
      app_rd_data_valid8 = (i >= 2);
      app_rd_data8 = beat8(i - 2);
      step();
    end
    app_rd_data_valid8 = 0;
    check("w8_en_off", app_en8, 1'b0);
    check("w8_ack", ws_ack8, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("w8_beat%0d", k), ws_dout8[k*128 +: 128], beat8(k));
    end
    step();
    check("w8_idle", dbg_state8, 3'd0);

    // Reset in RD after one beat, then a clean read @0x80.
    app_rdy = 1; ws_addr = 32'h40; ws_we = 0; ws_cyc = 1; ws_stb = 1;
    step();
    ws_cyc = 0; ws_stb = 0;
    step();
    step();
    app_rd_data_valid = 1; app_rd_data = RB0;
    step();
    app_rd_data_valid = 0; rst = 1;
    step();
    rst = 0;
    check("abort_state", dbg_state, 3'd0);
    check("abort_ack", ws_ack, 1'b0);
    check("abort_dout", ws_dout, 512'd0);
    step();
    check("abort_no_ack", ws_ack, 1'b0);
    ws_addr = 32'h80; ws_cyc = 1; ws_stb = 1;
    step();
    ws_cyc = 0; ws_stb = 0;
    check("rd2_addr0", app_addr, 28'h20);
    step();
    check("rd2_addr1", app_addr, 28'h28);
    step();
    app_rd_data_valid = 1; app_rd_data = DB0;
    step();
    check("rd2_noack_b0", ws_ack, 1'b0);
    app_rd_data = DB1;
    step();
    app_rd_data_valid = 0;
    check("rd2_ack", ws_ack, 1'b1);
    check("rd2_dout", ws_dout, {DB1, DB0});
    step();
    check("rd2_idle", dbg_state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_wb_line_bridge.md
# ddr_wb_line_bridge

Parametrised Wishbone-slave to MIG user-interface bridge that moves one cache line per transaction as `BEATS = LINE_BITS/APP_DATA_BITS` application beats. It sits between the line-granular memory arbiter and an external MIG core; clock generation and the MIG instance stay outside. It adds the following over the fixed 512/256 bridge:
- command and data issue run concurrently;
- requests are gated on calibration;
- out-of-range accesses complete immediately with an error ack.

## Interface
- `LINE_BITS`, 512, Wishbone line width; must be a power-of-two multiple of `APP_DATA_BITS`.
- `APP_DATA_BITS`, 256, MIG `app_wdf_data` / `app_rd_data` width.
- `APP_ADDR_BITS`, 28, MIG `app_addr` width.
- `BEAT_ADDR_STEP`, 8, `app_addr` increment per beat; power of two.
- `MEM_BYTES_LOG2`, 29, log2 of memory size in bytes.
- `clk`  in  1  MIG `ui_clk`. Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `ws_addr`  in  32  byte address. Bits below `log2(LINE_BITS/8)` are ignored.
- `ws_din`  in  `LINE_BITS`  write line.
- `ws_dm`  in  `LINE_BITS/8`  byte enables; 1 = write the byte.
- `ws_cyc`, `ws_stb`, `ws_we`  in  1 each  Wishbone classic request.
- `ws_ack`  out  1  one-cycle acknowledge.
- `ws_err`  out  1  qualifies `ws_ack`; 1 = address out of range.
- `ws_dout`  out  `LINE_BITS`  last completed read line.
- `calib_done`  in  1  MIG `init_calib_complete`.
- `app_addr`  out  `APP_ADDR_BITS`.
- `app_cmd`  out  3.
- `app_en`  out  1.
- `app_rdy`  in  1.
- `app_wdf_data`  out  `APP_DATA_BITS`.
- `app_wdf_mask`  out  `APP_DATA_BITS/8`  1 = byte masked (inverted `ws_dm` slice).
- `app_wdf_wren`, `app_wdf_end`  out  1 each.
- `app_wdf_rdy`  in  1.
- `app_rd_data`  in  `APP_DATA_BITS`.
- `app_rd_data_valid`  in  1.
- `dbg_state`  out  3  current state encoding.

## Operation
- States and encodings: IDLE=0, WR=1, RD=2, ACK=3.
- **IDLE** accepts a request when `ws_cyc & ws_stb & calib_done`. Without `calib_done` the request waits and no ack is given.
  - On accept: latch line address `ws_addr[MEM_BYTES_LOG2-1:log2(LINE_BITS/8)]`, and also `ws_din`/`ws_dm` when `ws_we`=1. Clear `cmd_cnt`, `dat_cnt`, `rd_cnt`.
  - If any `ws_addr` bit at or above `MEM_BYTES_LOG2` is set: `ws_ack`=1 and `ws_err`=1, go to ACK. No MIG activity.
  - Else if `ws_we`=1: write is posted. `ws_ack`=1, go to WR.
  - Else go to RD.
- **WR**
  - `app_en`=1 while `cmd_cnt<BEATS`; `cmd_cnt` increments on `app_rdy`. `app_cmd`=3'b000.
  - `app_wdf_wren` = `app_wdf_end` = 1 while `dat_cnt<BEATS`; `dat_cnt` increments on `app_wdf_rdy`.
  - The command and data counters are independent; either may lead.
  - Go to IDLE once both counters reach `BEATS`. The last increments may land in the same cycle.
- **RD**
  - `app_en`=1 while `cmd_cnt<BEATS`, `app_cmd`=3'b001.
  - On each `app_rd_data_valid`, beat `rd_cnt` is written into the read buffer at `[rd_cnt*APP_DATA_BITS +: APP_DATA_BITS]` and `rd_cnt` increments.
  - Data may return while commands are still being issued.
  - On the valid with `rd_cnt==BEATS-1`: copy the buffer (including this beat) to `ws_dout`, set `ws_ack`=1, go to ACK.
- **ACK**: clear `ws_ack` and `ws_err`, go to IDLE.
- Addressing:
  - `app_addr` = `((line << log2(BEATS)) + cmd_cnt) * BEAT_ADDR_STEP`, truncated/zero-extended to `APP_ADDR_BITS`.
  - `app_wdf_data` and `app_wdf_mask` are the `dat_cnt` slices.
- `ws_dout` changes only on read completion and holds its value otherwise, including across writes.

## Timing
- Reset values:
  - `ws_ack`=0, `ws_err`=0, state=IDLE, all counters 0, `ws_dout`=0.
  - `app_en`, `app_wdf_wren`, `app_wdf_end` = 0, since they are decoded from state and counters.
- Write ack comes one cycle after `stb` is sampled and lasts one cycle. The next request is accepted only after WR completes; minimum WR length is `BEATS` cycles.
- Read ack comes one cycle after the final `app_rd_data_valid`. Minimum read latency is 1 accept cycle + MIG latency + 1.
- Error ack comes one cycle after sampling; the block is back in IDLE 2 cycles after sampling.
- The block never accepts in the ack cycle, because state is not IDLE then.
- `app_en` and `app_wdf_wren` are held with constant addr/data until `app_rdy` / `app_wdf_rdy` is sampled high.
- `rst` mid-transaction aborts to IDLE with no ack. `rst` must be driven from MIG `ui_clk_sync_rst` or ORed with it, so no stale read data arrives afterwards.
- `calib_done` falling mid-transaction is ignored; it is sampled only in IDLE.

## Structure
- Package `ddr_wb_pkg` holds:
  - state encodings;
  - `MIG_CMD_WRITE`=3'b000 and `MIG_CMD_READ`=3'b001;
  - a `clog2` helper.
- Counters are `clog2(BEATS+1)` bits wide.
- One sub-module, `beat_counter`, is used three times. Ports: `clk`, `rst`, `clr`, `inc`, `cnt`, `done` (`cnt==BEATS`).
- Elaboration check: `LINE_BITS % APP_DATA_BITS == 0` and `BEATS` is a power of two.

## Test plan
- Defaults, `calib_done`=0 then 1 after 20 cycles, read @0x40:
  - no ack before calib;
  - after calib, `app_addr` sequence is 0x10, 0x18;
  - ack 1 cycle after the 2nd valid;
  - `ws_dout` = {beat1, beat0}.
- Write @0x1000, `ws_dm`=64'h00000000_FFFFFFFF, `app_wdf_rdy` high and `app_rdy` stalled for 5 cycles:
  - ack on cycle 1;
  - masks 32'h0, 32'hFFFFFFFF;
  - return to IDLE only after the 2nd `app_rdy`.
- Write data accepted before the command (`app_rdy` low, `app_wdf_rdy` high), then reversed:
  - both orders complete;
  - no extra beats issued.
- Read @0x2000_0000 (bit 29 set):
  - `ws_ack`=`ws_err`=1 one cycle after sampling;
  - `app_en` never asserted.
- `LINE_BITS`=1024, `APP_DATA_BITS`=128 (`BEATS`=8), read @0x80:
  - 8 commands at `app_addr` 0x40..0x78 step 8;
  - valids interleaved with commands;
  - line assembled in order.
- `rst` pulse in RD after 1 beat:
  - state IDLE, no ack;
  - next read completes correctly.
